sd_cmd_framer: RTL
==================

SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

Interface
REQ-001 Parameter: NCR_MAX, 8, maximum 0xFF poll bytes before R1 timeout (range 1..255).
REQ-002 clk  input  1  master clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to issue a command; sampled only in IDLE.
REQ-005 cmd_index  input  6  SD command number (CMD0, CMD8, CMD55, ACMD41, CMD58, CMD17, ...).
REQ-006 cmd_arg  input  32  command argument, sent MSB first.
REQ-007 resp_long  input  1  0 = R1 only; 1 = R1 plus 4 trailing bytes (R3/R7).
REQ-008 byte_tx  output  8  byte for the SPI byte engine.
REQ-009 byte_go  output  1  one-cycle pulse that starts one SPI byte transfer.
REQ-010 byte_done  input  1  one-cycle pulse from the SPI engine; byte_rx is valid in the same cycle.
REQ-011 byte_rx  input  8  byte received during the completed transfer.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse when the command/response completes.
REQ-014 r1  output  8  captured R1 byte; holds its value until the next accepted start.
REQ-015 resp_data  output  32  trailing bytes, first received in [31:24]; 0 when resp_long=0.
REQ-016 timeout  output  1  set with done when no R1 arrived; cleared on the next accepted start.

Function
REQ-017 The FSM shall have states IDLE, SEND, POLL, TRAIL and FINISH.
REQ-018 In IDLE, start=1 shall latch cmd_index, cmd_arg and resp_long, clear r1, resp_data and timeout, and enter SEND.
REQ-019 start while busy shall be ignored, with no effect on latched inputs or outputs.
REQ-020 SEND shall emit six bytes in order: {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
REQ-021 byte_go shall pulse the cycle after entering SEND, and thereafter the cycle after each byte_done, while bytes remain in the current phase.
REQ-022 Only one transfer shall be outstanding at a time; byte_done received outside an outstanding transfer shall be ignored.
REQ-023 After the 6th byte_done the FSM shall enter POLL and transmit 0xFF bytes.
REQ-024 POLL: the first byte_rx with bit7=0 shall be captured as r1, then go to TRAIL if resp_long=1, else FINISH.
REQ-025 POLL: after NCR_MAX consecutive received bytes with bit7=1, set r1=8'hFF and timeout=1, then go to FINISH; TRAIL shall be skipped.
REQ-026 TRAIL shall transmit four 0xFF bytes and shift byte_rx into resp_data MSB first, then go to FINISH.
REQ-027 FINISH shall pulse done for exactly one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-028 A new start shall be accepted no earlier than the cycle after done.
REQ-029 The poll and byte counters shall be sized for NCR_MAX and 6, and shall never wrap.

Reset
REQ-030 While rst_n=0, state shall be IDLE and byte_tx=8'hFF, byte_go=0, busy=0, done=0, r1=8'hFF, resp_data=0, timeout=0, all counters=0.
REQ-031 Reset mid-operation shall abort immediately with no further byte_go; a byte_done arriving after reset release shall be ignored.

Configuration
REQ-032 With SD_CRC7_EN defined, the CRC7 (x^7+x^3+1, init 0) shall be computed over the first five bytes.
REQ-033 Without SD_CRC7_EN, the last byte shall be 8'h95 for CMD0, 8'h87 for CMD8 and 8'h01 for all other commands.

Structure
REQ-034 Package sd_pkg shall hold the command index constants, the FSM state enum, the R1 bit positions and the NCR_MAX default.
REQ-035 Sub-module sd_crc7 shall implement a combinational byte-wise CRC7 update (crc_in, data -> crc_out), instantiated only under SD_CRC7_EN.

Verification
REQ-036 CMD0, arg 0, resp_long=0, R1 0x01 on the 2nd poll byte -> bytes 40 00 00 00 00 95, r1=0x01, done pulses once.
REQ-037 CMD8, arg 0x000001AA, resp_long=1, R7 01 00 00 01 AA -> last byte 0x87, r1=0x01, resp_data=0x000001AA.
REQ-038 CMD58 with SD_CRC7_EN, arg 0 -> last byte 0xFD; without SD_CRC7_EN -> last byte 0x01.
REQ-039 Card returns all 0xFF with NCR_MAX=8 -> exactly 14 byte_go pulses, timeout=1, r1=0xFF, resp_data=0.
REQ-040 start pulsed during POLL, and rst_n asserted during SEND byte 3 -> start ignored; after reset, outputs at reset values and no byte_go until the next start.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command framer.
package sd_pkg;

  localparam int unsigned NCR_MAX_DEFAULT = 8;
  localparam int unsigned CMD_BYTES       = 6;
  localparam int unsigned TRAIL_BYTES     = 4;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;

  // R1 bit positions; bit 7 is zero in any valid R1
  localparam int unsigned R1_IDLE        = 0;
  localparam int unsigned R1_ERASE_RESET = 1;
  localparam int unsigned R1_ILLEGAL_CMD = 2;
  localparam int unsigned R1_CRC_ERR     = 3;
  localparam int unsigned R1_ERASE_SEQ   = 4;
  localparam int unsigned R1_ADDR_ERR    = 5;
  localparam int unsigned R1_PARAM_ERR   = 6;
  localparam int unsigned R1_START       = 7;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    POLL,
    TRAIL,
    FINISH
  } sd_state_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    logic        resp_long;
  } sd_cmd_t;

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Host + SPI byte-engine signals of the command framer; slave = framer view.
interface sd_cmd_framer_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic [7:0]  byte_tx;
  logic        byte_go;
  logic        byte_done;
  logic [7:0]  byte_rx;
  logic        busy;
  logic        done;
  logic [7:0]  r1;
  logic [31:0] resp_data;
  logic        timeout;

  modport slave (
    input  start, cmd_index, cmd_arg, resp_long, byte_done, byte_rx,
    output byte_tx, byte_go, busy, done, r1, resp_data, timeout
  );

  modport master (
    output start, cmd_index, cmd_arg, resp_long, byte_done, byte_rx,
    input  byte_tx, byte_go, busy, done, r1, resp_data, timeout
  );
endinterface

// File: rtl/sd_crc7.sv
// Byte-wise CRC7 update, polynomial x^7 + x^3 + 1, data MSB first.
module sd_crc7 (
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);
  logic [6:0] w_crc;
  logic       w_fb;

  always_comb begin
    w_crc = crc_in;
    w_fb  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_fb  = w_crc[6] ^ data[i];
      w_crc = {w_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
    end
  end

  assign crc_out = w_crc;
endmodule

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command framer: sends a 6-byte command, polls for R1, collects R3/R7 trailer.
// Define SD_CRC7_EN to compute the CRC7 byte; otherwise fixed CRC bytes for CMD0/CMD8 are used.
module sd_cmd_framer
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX = NCR_MAX_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  sd_cmd_framer_if.slave sd
);
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned POLL_W = $clog2(NCR_MAX + 1);

  sd_state_e         r_state;
  sd_cmd_t           r_cmd;
  logic [CNT_W-1:0]  r_cnt;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              r_pending;
  logic              r_byte_go;
  logic [7:0]        r_byte_tx;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_r1;
  logic [31:0]       r_resp_data;
  logic              r_timeout;

  logic              w_done_ok;
  logic [CNT_W-1:0]  w_tx_sel;
  logic [7:0]        w_next_tx;
  logic [7:0]        w_crc_byte;
  logic [7:0]        w_hdr [0:4];

  // A byte_done only counts while a transfer is actually outstanding
  assign w_done_ok = sd.byte_done & r_pending;
  assign w_tx_sel  = w_done_ok ? r_cnt + CNT_W'(1) : CNT_W'(0);

  assign w_hdr[0] = {2'b01, r_cmd.index};
  assign w_hdr[1] = r_cmd.arg[31:24];
  assign w_hdr[2] = r_cmd.arg[23:16];
  assign w_hdr[3] = r_cmd.arg[15:8];
  assign w_hdr[4] = r_cmd.arg[7:0];

`ifdef SD_CRC7_EN
  logic [6:0] w_crc [0:5];
  assign w_crc[0] = 7'd0;
  for (genvar g = 0; g < 5; g++) begin : g_crc
    sd_crc7 u_crc7 (
      .crc_in  (w_crc[g]),
      .data    (w_hdr[g]),
      .crc_out (w_crc[g+1])
    );
  end
  assign w_crc_byte = {w_crc[5], 1'b1};
`else
  // Only CMD0 and CMD8 are CRC-checked by the card in SPI mode
  always_comb begin
    w_crc_byte = 8'h01;
    if (r_cmd.index == CMD0)      w_crc_byte = 8'h95;
    else if (r_cmd.index == CMD8) w_crc_byte = 8'h87;
  end
`endif

  always_comb begin
    w_next_tx = 8'hFF;
    case (w_tx_sel)
      3'd0:    w_next_tx = w_hdr[0];
      3'd1:    w_next_tx = w_hdr[1];
      3'd2:    w_next_tx = w_hdr[2];
      3'd3:    w_next_tx = w_hdr[3];
      3'd4:    w_next_tx = w_hdr[4];
      3'd5:    w_next_tx = w_crc_byte;
      default: w_next_tx = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_poll_cnt  <= '0;
      r_pending   <= 1'b0;
      r_byte_go   <= 1'b0;
      r_byte_tx   <= 8'hFF;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_r1        <= 8'hFF;
      r_resp_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_byte_go <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sd.start && !r_done) begin
            r_cmd.index     <= sd.cmd_index;
            r_cmd.arg       <= sd.cmd_arg;
            r_cmd.resp_long <= sd.resp_long;
            r_r1            <= 8'h00;
            r_resp_data     <= '0;
            r_timeout       <= 1'b0;
            r_busy          <= 1'b1;
            r_cnt           <= '0;
            r_poll_cnt      <= '0;
            r_state         <= SEND;
          end
        end
        SEND: begin
          if (!r_pending && r_cnt == '0) begin
            r_byte_go <= 1'b1;
            r_byte_tx <= w_next_tx;
            r_pending <= 1'b1;
          end else if (w_done_ok) begin
            r_byte_go <= 1'b1;
            if (r_cnt == CNT_W'(CMD_BYTES - 1)) begin
              r_cnt     <= '0;
              r_byte_tx <= 8'hFF;
              r_state   <= POLL;
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_byte_tx <= w_next_tx;
            end
          end
        end
        POLL: begin
          if (w_done_ok) begin
            if (!sd.byte_rx[R1_START]) begin
              r_r1 <= sd.byte_rx;
              if (r_cmd.resp_long) begin
                r_byte_go <= 1'b1;
                r_byte_tx <= 8'hFF;
                r_state   <= TRAIL;
              end else begin
                r_pending <= 1'b0;
                r_state   <= FINISH;
              end
            end else if (r_poll_cnt == POLL_W'(NCR_MAX - 1)) begin
              r_r1      <= 8'hFF;
              r_timeout <= 1'b1;
              r_pending <= 1'b0;
              r_state   <= FINISH;
            end else begin
              r_poll_cnt <= r_poll_cnt + POLL_W'(1);
              r_byte_go  <= 1'b1;
              r_byte_tx  <= 8'hFF;
            end
          end
        end
        TRAIL: begin
          if (w_done_ok) begin
            r_resp_data <= {r_resp_data[23:0], sd.byte_rx};
            if (r_cnt == CNT_W'(TRAIL_BYTES - 1)) begin
              r_cnt     <= '0;
              r_pending <= 1'b0;
              r_state   <= FINISH;
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_byte_go <= 1'b1;
              r_byte_tx <= 8'hFF;
            end
          end
        end
        FINISH: begin
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_cnt      <= '0;
          r_poll_cnt <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sd.byte_tx   = r_byte_tx;
  assign sd.byte_go   = r_byte_go;
  assign sd.busy      = r_busy;
  assign sd.done      = r_done;
  assign sd.r1        = r_r1;
  assign sd.resp_data = r_resp_data;
  assign sd.timeout   = r_timeout;
endmodule
